// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for mem_arbiter: FSM states, owner codes and grant-vector helpers.
// Also used by arb_pick.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    // Owner codes double as bit positions in the one-hot grant vector.
    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    function automatic logic gnt_to_owner(input logic [1:0] gnt);
        return gnt[OWN_LSU] ? OWN_LSU : OWN_IF;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Two-requester grant selection: a lone requester wins.
// On a tie, the requester that did not win most recently wins.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       if_valid,
    input  logic       lsu_valid,
    input  logic       last_own,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (if_valid && lsu_valid) begin
            if (last_own == OWN_LSU) begin
                gnt[OWN_IF] = 1'b1;
            end else begin
                gnt[OWN_LSU] = 1'b1;
            end
        end else if (lsu_valid) begin
            gnt[OWN_LSU] = 1'b1;
        end else if (if_valid) begin
            gnt[OWN_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one memory port, one at a time.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise LSU has fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [AW-1:0]     if_req_addr,
    output logic              if_rsp_valid,
    output logic [DW-1:0]     if_rsp_data,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [AW-1:0]     lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [DW-1:0]     lsu_req_wdata,
    input  logic [DW/8-1:0]   lsu_req_wmask,
    output logic              lsu_rsp_valid,
    output logic [DW-1:0]     lsu_rsp_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [AW-1:0]     mem_req_addr,
    output logic              mem_req_wen,
    output logic [DW-1:0]     mem_req_wdata,
    output logic [DW/8-1:0]   mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DW-1:0]     mem_rsp_rdata,

    output logic              busy,
    output logic              err
);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   wmask_q, wmask_d;
    logic              err_q, err_d;
    logic              last_own;
    logic [1:0]        gnt;
    logic              accept;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = gnt_to_owner(gnt);
        end
    end

    // Resetting to IF lets LSU win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWN_IF;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_own = last_q;
`else
    assign last_own = OWN_IF;
`endif

    arb_pick u_arb_pick (
        .if_valid  (if_req_valid),
        .lsu_valid (lsu_req_valid),
        .last_own  (last_own),
        .gnt       (gnt)
    );

    assign accept = (state_q == StIdle) && (if_req_valid || lsu_req_valid);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept)        state_d = StIssue;
            StIssue: if (mem_req_ready) state_d = StWait;
            StWait:  if (mem_rsp_valid) state_d = StIdle;
            default:                    state_d = StIdle;
        endcase
    end

    // Command latch and sticky error.
    always_comb begin
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        err_d   = err_q | (mem_rsp_valid && (state_q != StWait));
        if (accept) begin
            owner_d = gnt_to_owner(gnt);
            if (gnt[OWN_LSU]) begin
                addr_d  = lsu_req_addr;
                wen_d   = lsu_req_wen;
                wdata_d = lsu_req_wdata;
                wmask_d = lsu_req_wmask;
            end else begin
                addr_d  = if_req_addr;
                wen_d   = 1'b0;
                wdata_d = '0;
                wmask_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_IF;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            err_q   <= err_d;
        end
    end

    // Outputs. Readies are gated by rst_n so they stay low while reset is asserted.
    always_comb begin
        if_req_ready  = rst_n && (state_q == StIdle) && gnt[OWN_IF] && if_req_valid;
        lsu_req_ready = rst_n && (state_q == StIdle) && gnt[OWN_LSU] && lsu_req_valid;
        mem_req_valid = (state_q == StIssue);
        mem_req_addr  = addr_q;
        mem_req_wen   = wen_q;
        mem_req_wdata = wdata_q;
        mem_req_wmask = wmask_q;
        if_rsp_valid  = (state_q == StWait) && mem_rsp_valid && (owner_q == OWN_IF);
        lsu_rsp_valid = (state_q == StWait) && mem_rsp_valid && (owner_q == OWN_LSU);
        if_rsp_data   = if_rsp_valid ? mem_rsp_rdata : '0;
        lsu_rsp_rdata = lsu_rsp_valid ? mem_rsp_rdata : '0;
        busy          = (state_q != StIdle);
        err           = err_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req_valid, if_req_ready, if_rsp_valid;
    logic [AW-1:0] if_req_addr;
    logic [DW-1:0] if_rsp_data;
    logic          lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid;
    logic [AW-1:0] lsu_req_addr;
    logic [DW-1:0] lsu_req_wdata, lsu_rsp_rdata;
    logic [MW-1:0] lsu_req_wmask;
    logic          mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata, mem_rsp_rdata;
    logic [MW-1:0] mem_req_wmask;
    logic          busy, err;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_req_addr   (if_req_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wen   (lsu_req_wen),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_wmask (lsu_req_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_rdata (lsu_rsp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .busy          (busy),
        .err           (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit rr_en();
`ifdef MEM_ARB_RR_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        if_v;
        logic [63:0] if_a;
        logic        lsu_v;
        logic [63:0] lsu_a;
        logic        wen;
        logic [63:0] wd;
        logic [7:0]  wm;
        logic        mrdy;
        logic        rspv;
        logic [63:0] rd;
    } in_t;

    typedef struct {
        logic        ifr;
        logic        lsr;
        logic        mv;
        logic [63:0] ma;
        logic        mw;
        logic [63:0] mwd;
        logic [7:0]  mm;
        logic        ifv;
        logic        lsv;
        logic [63:0] rd;
        logic        chk_rd;
        logic        busy;
        logic        err;
    } ex_t;

    typedef struct {
        in_t i;
        ex_t e;
    } vec_t;

    function automatic in_t ci(input logic if_v, input logic [63:0] if_a, input logic lsu_v,
                               input logic [63:0] lsu_a, input logic wen, input logic [63:0] wd,
                               input logic [7:0] wm, input logic mrdy, input logic rspv,
                               input logic [63:0] rd);
        in_t r;
        r.if_v = if_v; r.if_a = if_a; r.lsu_v = lsu_v; r.lsu_a = lsu_a; r.wen = wen;
        r.wd = wd; r.wm = wm; r.mrdy = mrdy; r.rspv = rspv; r.rd = rd;
        return r;
    endfunction

    function automatic ex_t ce(input logic ifr, input logic lsr, input logic mv,
                               input logic [63:0] ma, input logic mw, input logic [63:0] mwd,
                               input logic [7:0] mm, input logic ifv, input logic lsv,
                               input logic [63:0] rd, input logic chk_rd, input logic bsy,
                               input logic er);
        ex_t r;
        r.ifr = ifr; r.lsr = lsr; r.mv = mv; r.ma = ma; r.mw = mw; r.mwd = mwd; r.mm = mm;
        r.ifv = ifv; r.lsv = lsv; r.rd = rd; r.chk_rd = chk_rd; r.busy = bsy; r.err = er;
        return r;
    endfunction

    function automatic vec_t mkv(input in_t i, input ex_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        return v;
    endfunction

    task automatic drive(input in_t i);
        if_req_valid  = i.if_v;
        if_req_addr   = i.if_a;
        lsu_req_valid = i.lsu_v;
        lsu_req_addr  = i.lsu_a;
        lsu_req_wen   = i.wen;
        lsu_req_wdata = i.wd;
        lsu_req_wmask = i.wm;
        mem_req_ready = i.mrdy;
        mem_rsp_valid = i.rspv;
        mem_rsp_rdata = i.rd;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string p;
        p = $sformatf("vec%0d", idx);
        drive(v.i);
        @(negedge clk);
        chk({p, " if_req_ready"}, if_req_ready, v.e.ifr);
        chk({p, " lsu_req_ready"}, lsu_req_ready, v.e.lsr);
        chk({p, " mem_req_valid"}, mem_req_valid, v.e.mv);
        if (v.e.mv) begin
            chk({p, " mem_req_addr"}, mem_req_addr, v.e.ma);
            chk({p, " mem_req_wen"}, mem_req_wen, v.e.mw);
            chk({p, " mem_req_wdata"}, mem_req_wdata, v.e.mwd);
            chk({p, " mem_req_wmask"}, mem_req_wmask, v.e.mm);
        end
        chk({p, " if_rsp_valid"}, if_rsp_valid, v.e.ifv);
        chk({p, " lsu_rsp_valid"}, lsu_rsp_valid, v.e.lsv);
        if (v.e.chk_rd && v.e.ifv) chk({p, " if_rsp_data"}, if_rsp_data, v.e.rd);
        if (v.e.chk_rd && v.e.lsv) chk({p, " lsu_rsp_rdata"}, lsu_rsp_rdata, v.e.rd);
        chk({p, " busy"}, busy, v.e.busy);
        chk({p, " err"}, err, v.e.err);
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    // At most one outstanding transaction; "sent" means the memory has taken the command.
    bit          m_have, m_sent, m_own_lsu, m_last_lsu, m_err, m_wen;
    logic [63:0] m_addr, m_wd;
    logic [7:0]  m_wm;

    task automatic model_reset();
        m_have = 0; m_sent = 0; m_own_lsu = 0; m_last_lsu = 0; m_err = 0;
        m_wen = 0; m_addr = '0; m_wd = '0; m_wm = '0;
    endtask

    task automatic model_cycle();
        bit pick_lsu, acc, rsp;
        @(negedge clk);
        pick_lsu = lsu_req_valid && !(if_req_valid && rr_en() && m_last_lsu);
        acc      = !m_have && (if_req_valid || lsu_req_valid);
        rsp      = m_have && m_sent && mem_rsp_valid;
        chk("rnd if_req_ready", if_req_ready, acc && !pick_lsu);
        chk("rnd lsu_req_ready", lsu_req_ready, acc && pick_lsu);
        chk("rnd mem_req_valid", mem_req_valid, m_have && !m_sent);
        if (m_have && !m_sent) begin
            chk("rnd mem_req_addr", mem_req_addr, m_addr);
            chk("rnd mem_req_wen", mem_req_wen, m_wen);
            chk("rnd mem_req_wdata", mem_req_wdata, m_wd);
            chk("rnd mem_req_wmask", mem_req_wmask, m_wm);
        end
        chk("rnd if_rsp_valid", if_rsp_valid, rsp && !m_own_lsu);
        chk("rnd lsu_rsp_valid", lsu_rsp_valid, rsp && m_own_lsu);
        if (rsp && !m_own_lsu) chk("rnd if_rsp_data", if_rsp_data, mem_rsp_rdata);
        if (rsp && m_own_lsu && !m_wen) chk("rnd lsu_rsp_rdata", lsu_rsp_rdata, mem_rsp_rdata);
        chk("rnd busy", busy, m_have);
        chk("rnd err", err, m_err);
        if (mem_rsp_valid && !(m_have && m_sent)) m_err = 1;
        if (acc) begin
            m_have = 1; m_sent = 0; m_own_lsu = pick_lsu; m_last_lsu = pick_lsu;
            m_addr = pick_lsu ? lsu_req_addr : if_req_addr;
            m_wen  = pick_lsu ? lsu_req_wen : 1'b0;
            m_wd   = pick_lsu ? lsu_req_wdata : '0;
            m_wm   = pick_lsu ? lsu_req_wmask : '0;
        end else if (m_have && !m_sent && mem_req_ready) begin
            m_sent = 1;
        end else if (rsp) begin
            m_have = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        drive(ci(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs(input bit allow_stray);
        if_req_valid  = ($urandom_range(0, 2) != 0);
        if_req_addr   = {$urandom, $urandom};
        lsu_req_valid = ($urandom_range(0, 2) != 0);
        lsu_req_addr  = {$urandom, $urandom};
        lsu_req_wen   = $urandom_range(0, 1) != 0;
        lsu_req_wdata = {$urandom, $urandom};
        lsu_req_wmask = 8'($urandom);
        mem_req_ready = ($urandom_range(0, 2) != 0);
        mem_rsp_rdata = {$urandom, $urandom};
        if (allow_stray) mem_rsp_valid = ($urandom_range(0, 9) == 0);
        else mem_rsp_valid = m_have && m_sent && ($urandom_range(0, 2) != 0);
    endtask

    vec_t tbl[$];
    bit   grants[$];

    localparam logic [63:0] A = 64'h8000_0000;
    localparam logic [63:0] S = 64'h8000_1000;
    localparam logic [63:0] B = 64'h8000_0040;
    localparam logic [63:0] L = 64'h0000_0100;
    localparam logic [63:0] D = 64'hDEAD_BEEF;

    initial begin
        // Reset with both requesters asserting valid: everything must read zero.
        rst_n = 1'b0;
        idle_inputs();
        if_req_valid  = 1'b1;
        lsu_req_valid = 1'b1;
        mem_rsp_valid = 1'b1;
        #12;
        chk("rst if_req_ready", if_req_ready, 0);
        chk("rst lsu_req_ready", lsu_req_ready, 0);
        chk("rst mem_req_valid", mem_req_valid, 0);
        chk("rst mem_req_addr", mem_req_addr, 0);
        chk("rst mem_req_wmask", mem_req_wmask, 0);
        chk("rst if_rsp_valid", if_rsp_valid, 0);
        chk("rst lsu_rsp_valid", lsu_rsp_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst err", err, 0);
        do_reset();

        // IF fetch, LSU/IF tie with store, backpressure, and a load.
        tbl.push_back(mkv(ci(1, A, 0, 0, 0, 0, 0, 1, 0, 0), ce(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(ci(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ce(0, 0, 1, A, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        tbl.push_back(mkv(ci(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ce(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        tbl.push_back(mkv(ci(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h13),
                          ce(0, 0, 0, 0, 0, 0, 0, 1, 0, 64'h13, 1, 1, 0)));
        tbl.push_back(mkv(ci(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ce(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(ci(1, B, 1, S, 1, D, 8'hFF, 1, 0, 0),
                          ce(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(ci(1, B, 0, 0, 0, 0, 0, 1, 0, 0),
                          ce(0, 0, 1, S, 1, D, 8'hFF, 0, 0, 0, 0, 1, 0)));
        tbl.push_back(mkv(ci(1, B, 0, 0, 0, 0, 0, 1, 1, 64'hAB),
                          ce(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0)));
        tbl.push_back(mkv(ci(1, B, 0, 0, 0, 0, 0, 0, 0, 0), ce(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(mkv(ci(1, B, 1, L + 64'(k), 1, 64'(k), 8'h0F, 0, 0, 0),
                              ce(0, 0, 1, B, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        end
        tbl.push_back(mkv(ci(1, B, 1, L, 0, 0, 0, 1, 0, 0), ce(0, 0, 1, B, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        tbl.push_back(mkv(ci(0, 0, 1, L, 0, 0, 0, 1, 1, 64'h55),
                          ce(0, 0, 0, 0, 0, 0, 0, 1, 0, 64'h55, 1, 1, 0)));
        tbl.push_back(mkv(ci(0, 0, 1, L, 0, 0, 0, 1, 0, 0), ce(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(ci(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ce(0, 0, 1, L, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        tbl.push_back(mkv(ci(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h77),
                          ce(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h77, 1, 1, 0)));
        tbl.push_back(mkv(ci(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ce(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        foreach (tbl[i]) run_vec(i, tbl[i]);

        // Stray response in IDLE sets err without forwarding anything.
        idle_inputs();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h99;
        @(negedge clk);
        chk("stray if_rsp_valid", if_rsp_valid, 0);
        chk("stray lsu_rsp_valid", lsu_rsp_valid, 0);
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("stray err", err, 1);

        // Reset while in WAIT drops the transaction; a late response is then a stray.
        @(posedge clk);
        #1;
        if_req_valid  = 1'b1;
        if_req_addr   = 64'h200;
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("wait busy", busy, 1);
        chk("wait mem_req_valid", mem_req_valid, 0);
        rst_n         = 1'b0;
        if_req_valid  = 1'b1;
        lsu_req_valid = 1'b1;
        #2;
        chk("wrst busy", busy, 0);
        chk("wrst err", err, 0);
        chk("wrst if_req_ready", if_req_ready, 0);
        chk("wrst lsu_req_ready", lsu_req_ready, 0);
        chk("wrst mem_req_valid", mem_req_valid, 0);
        chk("wrst mem_req_addr", mem_req_addr, 0);
        @(negedge clk);
        rst_n         = 1'b1;
        if_req_valid  = 1'b0;
        lsu_req_valid = 1'b0;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("late if_rsp_valid", if_rsp_valid, 0);
        chk("late lsu_rsp_valid", lsu_rsp_valid, 0);
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("late err", err, 1);

        // Both requesters held valid for four transactions.
        do_reset();
        if_req_valid  = 1'b1;
        lsu_req_valid = 1'b1;
        mem_req_ready = 1'b1;
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            @(negedge clk);
            if (lsu_req_ready) grants.push_back(1'b1);
            else if (if_req_ready) grants.push_back(1'b0);
            @(posedge clk);
            #1;
            mem_rsp_valid = busy && !mem_req_valid;
        end
        chk("tie grant count", grants.size(), 4);
        foreach (grants[k]) begin
            chk($sformatf("tie grant%0d lsu", k), grants[k], rr_en() ? (k % 2 == 0) : 1'b1);
        end

        // Randomized traffic: well-behaved memory, then with stray responses.
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            rand_inputs(1'b0);
            model_cycle();
        end
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            rand_inputs(1'b1);
            model_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
